// File: rtl/machine_segment_decode_if.sv
// -----------------------------------------------------------------------------
// machine_segment_decode_if
//
// Purpose: groups the segment input stream, the decoded character output
//          stream and the error-reporting signals of machine_segment_decode
//          into one bundle.
//
// Parameters:
//   ERRW        error counter width
//
// Signals:
//   seg_in      8-bit segment pattern              (producer -> decoder)
//   seg_valid   seg_in is valid this cycle         (producer -> decoder)
//   seg_ready   decoder accepts seg_in this cycle  (decoder -> producer)
//   char_out    decoded ASCII, zero-extended to 32 (decoder -> consumer)
//   char_valid  char_out holds the FIFO head       (decoder -> consumer)
//   char_ready  consumer takes the head this cycle (consumer -> decoder)
//   err_clr     clear the error counter and sticky (controller -> decoder)
//   err_count   saturating count of unknown patterns
//   err_sticky  set on any unknown pattern
//
// Modports:
//   master      the environment around the decoder (producer/consumer side)
//   slave       the decoder itself
// -----------------------------------------------------------------------------
interface machine_segment_decode_if #(
   parameter int ERRW = 8
);
   logic [7:0]      seg_in;
   logic            seg_valid;
   logic            seg_ready;
   logic [31:0]     char_out;
   logic            char_valid;
   logic            char_ready;
   logic            err_clr;
   logic [ERRW-1:0] err_count;
   logic            err_sticky;

   modport master (
      output seg_in, seg_valid, char_ready, err_clr,
      input  seg_ready, char_out, char_valid, err_count, err_sticky
   );

   modport slave (
      input  seg_in, seg_valid, char_ready, err_clr,
      output seg_ready, char_out, char_valid, err_count, err_sticky
   );
endinterface

// File: rtl/machine_segment_decode.sv
// -----------------------------------------------------------------------------
// machine_segment_decode
//
// Purpose: inverse of the display character encoder on the display
//          loopback/capture path. Each accepted 8-bit segment pattern is
//          mapped back to its ASCII code and queued in a small FIFO for a
//          downstream checker. Blank patterns (0x00) are dropped silently;
//          any other unmapped pattern is dropped and counted as an error.
//
// Parameters:
//   DEPTH   FIFO entries, power of two in 2..16
//   ERRW    error counter width
//
// Ports:
//   system1000      clock
//   system1000_rst  synchronous reset, active-high
//   bus             machine_segment_decode_if.slave
//                     seg_in/seg_valid/seg_ready      segment input stream
//                     char_out/char_valid/char_ready  decoded character stream
//                     err_clr/err_count/err_sticky    error reporting
//
// Build option:
//   MACHINE_SEGDEC_ERRCNT_EN  when defined, the saturating error counter and
//                             err_sticky are built; when undefined both
//                             outputs are tied to 0 and err_clr is ignored.
// -----------------------------------------------------------------------------
module machine_segment_decode #(
   parameter int DEPTH = 4,
   parameter int ERRW  = 8
) (
   input logic                     system1000,
   input logic                     system1000_rst,
   machine_segment_decode_if.slave bus
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   // ---------------------------------------------------------------------------
   // Pattern decode
   // ---------------------------------------------------------------------------
   logic [7:0] ascii;
   logic       known;

   always_comb begin
      // NOTE: every combinational output gets a default first, so no path
      //       through the case can leave a value held (no latch).
      ascii = 8'h00;
      known = 1'b1;
      case (bus.seg_in)
         8'h74:   ascii = 8'd104; // 'h'
         8'h7B:   ascii = 8'd101; // 'e'
         8'h30:   ascii = 8'd108; // 'l'
         8'h5C:   ascii = 8'd111; // 'o'
         8'h08:   ascii = 8'd95;  // '_'
         8'h2A:   ascii = 8'd119; // 'w'
         8'h31:   ascii = 8'd114; // 'r'
         8'h5E:   ascii = 8'd100; // 'd'
         8'h82:   ascii = 8'd33;  // '!'
         default: known = 1'b0;
      endcase
   end

   // ---------------------------------------------------------------------------
   // FIFO control
   // ---------------------------------------------------------------------------
   logic [7:0]    mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [CW-1:0] count;

   logic full;
   logic empty;
   logic accept;
   logic push;
   logic pop;

   assign full   = (count == CW'(DEPTH));
   assign empty  = (count == '0);

   // seg_ready looks only at the registered occupancy: a pop in the same
   // cycle does not open a slot until the next cycle (no bypass path).
   assign bus.seg_ready = !full;
   assign accept        = bus.seg_valid && !full;
   assign push          = accept && known;
   assign pop           = !empty && bus.char_ready;

   // Pointers are exactly log2(DEPTH) bits wide, so the natural binary
   // overflow implements the modulo-DEPTH wrap.
   always_ff @(posedge system1000) begin
      if (system1000_rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every
         //       register samples pre-edge values regardless of ordering.
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         if (push && !pop)      count <= count + 1'b1;
         else if (!push && pop) count <= count - 1'b1;
      end
   end

   // NOTE: the storage array has no reset; stale contents are harmless
   //       because the read port is masked while the FIFO is empty.
   always_ff @(posedge system1000) begin
      if (push) mem[wr_ptr] <= ascii;
   end

   assign bus.char_valid = !empty;
   assign bus.char_out   = empty ? 32'h0 : {24'h0, mem[rd_ptr]};

   // ---------------------------------------------------------------------------
   // Error reporting
   // ---------------------------------------------------------------------------
`ifdef MACHINE_SEGDEC_ERRCNT_EN
   logic [ERRW-1:0] err_cnt;
   logic            err_flag;
   logic            bad;

   // Blank is a legal "nothing to show" glyph and never counts as an error.
   assign bad = accept && !known && (bus.seg_in != 8'h00);

   // err_clr wins over a coincident error so software sees a clean zero.
   always_ff @(posedge system1000) begin
      if (system1000_rst || bus.err_clr) begin
         err_cnt  <= '0;
         err_flag <= 1'b0;
      end else if (bad) begin
         if (err_cnt != {ERRW{1'b1}}) err_cnt <= err_cnt + 1'b1;
         err_flag <= 1'b1;
      end
   end

   assign bus.err_count  = err_cnt;
   assign bus.err_sticky = err_flag;
`else
   assign bus.err_count  = '0;
   assign bus.err_sticky = 1'b0;
`endif

endmodule
